// File: rtl/io_cfg_pkg.sv
// Shared constants and types for the configurable IO tiles: register selects,
// mode bit layout and reset values.
package io_cfg_pkg;

  localparam logic [7:0] CFG_REG_OE   = 8'd0;
  localparam logic [7:0] CFG_REG_MODE = 8'd1;

  localparam int MODE_IN_SYNC = 0;
  localparam int MODE_OUT_REG = 1;

  typedef struct packed {
    logic out_reg_en;
    logic in_sync_en;
  } mode_t;

  localparam mode_t MODE_RST = '{out_reg_en: 1'b0, in_sync_en: 1'b0};

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [7:0]  sel;
    logic [31:0] data;
  } cfg_req_t;

  function automatic logic cfg_hit(input logic [31:0] addr, input logic [15:0] id);
    return addr[15:0] == id;
  endfunction

endpackage

// File: rtl/io_sync_chain.sv
// Multi-bit flop chain used as an input synchroniser; always clocking, async clear.
module io_sync_chain #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] st_q, st_d;

  always_comb begin
    st_d = {st_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= '0;
    else          st_q <= st_d;
  end

  assign q = st_q[STAGES-1];

endmodule

// File: rtl/io_nbit_cfg.sv
// WIDTH-bit bidirectional IO tile: per-pad direction and tile mode set over the
// config bus, optional input synchroniser and optional registered output.
module io_nbit_cfg
  import io_cfg_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] p2f,
  input  logic [WIDTH-1:0] f2p,
  input  logic [31:0]      config_addr,
  input  logic [31:0]      config_data,
  input  logic             config_write,
  input  logic             config_read,
  input  logic [15:0]      tile_id,
  output logic [31:0]      read_data
);

  cfg_req_t         req;
  logic             hit;
  logic [WIDTH-1:0] oe_q, oe_d;
  mode_t            mode_q, mode_d;
  logic [31:0]      rd_q, rd_d, rd_val;
  logic [WIDTH-1:0] f2p_r_q, f2p_r_d;
  logic [WIDTH-1:0] f2p_out, pad_sync;
  logic             unused_cfg;

  assign req = '{wr: config_write, rd: config_read,
                 sel: config_addr[23:16], data: config_data};
  assign hit = cfg_hit(config_addr, tile_id);
  assign unused_cfg = ^config_addr[31:24];

  // Readback mux sees the pre-write register values, so a same-cycle
  // write+read returns the old contents.
  always_comb begin
    rd_val = '0;
    case (req.sel)
      CFG_REG_OE:   rd_val[WIDTH-1:0] = oe_q;
      CFG_REG_MODE: rd_val[1:0]       = mode_q;
      default:      rd_val            = '0;
    endcase
  end

  always_comb begin
    oe_d    = oe_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    f2p_r_d = f2p;
    if (req.wr && hit) begin
      if (req.sel == CFG_REG_OE)   oe_d   = req.data[WIDTH-1:0];
      if (req.sel == CFG_REG_MODE) mode_d = mode_t'(req.data[1:0]);
    end
    if (req.rd && hit) rd_d = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_q    <= '0;
      mode_q  <= MODE_RST;
      rd_q    <= '0;
      f2p_r_q <= '0;
    end else begin
      oe_q    <= oe_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      f2p_r_q <= f2p_r_d;
    end
  end

  assign read_data = rd_q;
  assign f2p_out   = mode_q.out_reg_en ? f2p_r_q : f2p;

  // oe_q clears asynchronously, so reset releases the pads without a clock edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad[i] = oe_q[i] ? f2p_out[i] : 1'bz;
  end

  io_sync_chain #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pad),
    .q       (pad_sync)
  );

  assign p2f = mode_q.in_sync_en ? pad_sync : pad;

endmodule

// File: doc/io_nbit_cfg.md
Name: io_nbit_cfg

Overview:
- Parametrised multi-bit successor of the 1-bit IO tile.
- Drives WIDTH bidirectional pads, each with its own direction. Direction and per-tile mode are held in config registers written over the global config bus, addressed by tile_id.
- Pad inputs can optionally pass through a 2-flop synchroniser. Fabric outputs can optionally be registered.
- Sits at the array boundary, between the IO pads and the fabric routing.

Parameters:
- WIDTH, 4, number of pads/bits per tile (1..32).
- SYNC_STAGES, 2, depth of the input synchroniser chain (2..3).

Ports:
- clk  input  1  tile clock.
- reset_n  input  1  asynchronous, active-low reset.
- pad  inout  WIDTH  bidirectional pad bits.
- p2f  output  WIDTH  pad-to-fabric data.
- f2p  input  WIDTH  fabric-to-pad data.
- config_addr  input  32  [15:0] tile select, [23:16] register select, [31:24] ignored.
- config_data  input  32  write data.
- config_write  input  1  write strobe, 1 cycle.
- config_read  input  1  read strobe, 1 cycle.
- tile_id  input  16  static tile identifier.
- read_data  output  32  registered readback.

Behaviour:
- Tile hit: config_addr[15:0]==tile_id.
  - reg 0 (config_addr[23:16]==0): oe_reg[WIDTH-1:0]. Bit i=1 drives pad[i].
  - reg 1 (config_addr[23:16]==1): mode_reg[1:0]. Bit0 in_sync_en, bit1 out_reg_en.
  - Other register selects: writes ignored, reads return 0.
- Writes: on posedge clk when config_write && hit. Takes config_data[WIDTH-1:0] for reg 0, [1:0] for reg 1. Upper data bits ignored.
- Reads: when config_read && hit, read_data loads the zero-extended register value on the next posedge (latency 1).
  - read_data holds its value until the next hit read.
  - A read with no tile hit leaves read_data unchanged.
- Simultaneous write and read, same register: read returns the pre-write value.
- Output path:
  - f2p_q = out_reg_en ? f2p registered on posedge clk : f2p.
  - pad[i] = oe_reg[i] ? f2p_q[i] : 1'bz.
  - The output register samples continuously, so toggling out_reg_en takes effect the next cycle with no bubble.
- Input path:
  - p2f = in_sync_en ? last stage of the SYNC_STAGES flop chain on pad : pad (combinational).
  - The chain always runs. Enabling sync gives stale-free data after SYNC_STAGES cycles.
  - A driven pad loops back: p2f reflects f2p_q.
- Reset (reset_n low, async assert, sync release):
  - oe_reg=0, so all pads are inputs (Hi-Z).
  - mode_reg=0.
  - Sync chain, output register and read_data all 0.
  - Mid-operation reset releases the pads within the same cycle, without waiting for a clock edge.
- A direction change takes effect the cycle after the write edge. No glitch protection beyond that; software sequences oe changes.

Decomposition:
- Shared package io_cfg_pkg holds:
  - register-select constants CFG_REG_OE=8'd0 and CFG_REG_MODE=8'd1;
  - mode bit indices MODE_IN_SYNC=0 and MODE_OUT_REG=1;
  - reset values.
- One natural sub-module, io_sync_chain. Parameterised by width and stages, reset_n async clear. Instantiated once for the input path; reused by future IO tiles.
- Config decode, register file and pad muxing stay in the top module.

Test Plan:
- Reset then idle: pad all Z; p2f follows external pad 4'b1010 the same cycle; read of reg 0 gives read_data=0 one cycle later.
- Write reg 0 = 32'h0000_0005 with tile_id match, f2p=4'b1111: from the next cycle pad=4'bz1z1 and p2f[0]=p2f[2]=1 via loopback.
- Write with config_addr[15:0]!=tile_id: oe_reg unchanged; a hit read returns the old value and a miss read leaves read_data unchanged.
- Write mode=2'b01 with external pad toggling 0->1: p2f rises exactly SYNC_STAGES cycles later. Write mode=2'b10 with oe=4'hF: pad lags f2p by one cycle.
- Same-cycle write 0x3 and read of reg 0, previous value 0xC: read_data=0xC, then a later read gives 0x3.
- reset_n asserted mid-cycle while pads are driven: pads go Z immediately, before any clk edge, and read_data=0. After release, a write to reg 2 reads back 0.
